// File: rtl/sensor_packet_tx.sv
// Sensor link transmitter: snapshots sensor, fault and actuator state and sends it
// as an 8-byte packet {AA, temp, hum, light, soil, fault, act, csum} over UART 8N1.
module sensor_packet_tx #(
  parameter int unsigned CLKS_PER_BIT = 32'd868,
  parameter int unsigned AUTO_PERIOD  = 32'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sensor_temp,
  input  logic [1:0] sensor_humidity,
  input  logic [1:0] sensor_light,
  input  logic [1:0] sensor_soil,
  input  logic [7:0] fault_flags,
  input  logic [7:0] actuator_status,
  input  logic       send_req,
  output logic       uart_tx,
  output logic       busy,
  output logic       pkt_done,
  output logic [7:0] pkt_count
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 32'd1) ? $clog2(CLKS_PER_BIT) : 32'd1;
  localparam int unsigned AP    = (AUTO_PERIOD > 32'd0) ? AUTO_PERIOD : 32'd1;
  localparam int unsigned TMR_W = (AP > 32'd1) ? $clog2(AP) : 32'd1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 32'd1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(AP - 32'd1);
  localparam logic             AUTO_EN  = (AUTO_PERIOD != 32'd0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  function automatic logic [7:0] calc_csum(input logic [1:0] t, input logic [1:0] h,
                                           input logic [1:0] l, input logic [1:0] s,
                                           input logic [7:0] f, input logic [7:0] a);
    calc_csum = {6'd0, t} + {6'd0, h} + {6'd0, l} + {6'd0, s} + f + a;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [2:0]       bit_idx_r, bit_idx_nxt_s;
  logic [2:0]       byte_idx_r, byte_idx_nxt_s;
  logic             pending_r, pending_nxt_s;
  logic [TMR_W-1:0] timer_r;
  logic [1:0]       temp_r, hum_r, light_r, soil_r;
  logic [7:0]       fault_r, act_r, csum_r;
  logic             uart_tx_r, busy_r, pkt_done_r;
  logic [7:0]       pkt_count_r;
  logic             trig_s, bit_end_s, load_s, done_s, tx_bit_s;
  logic [7:0]       cur_byte_s;

  assign trig_s    = send_req | (AUTO_EN & (timer_r == TMR_LAST));
  assign bit_end_s = (cnt_r == CNT_LAST);

  // Free-running period timer for automatic sends
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_r <= '0;
    end else if (timer_r == TMR_LAST) begin
      timer_r <= '0;
    end else begin
      timer_r <= timer_r + TMR_W'(1);
    end
  end

  // Next-state logic; a trigger while busy is remembered one deep
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    bit_idx_nxt_s  = bit_idx_r;
    byte_idx_nxt_s = byte_idx_r;
    pending_nxt_s  = pending_r;
    load_s         = 1'b0;
    done_s         = 1'b0;
    if (state_r != IDLE && trig_s) begin
      pending_nxt_s = 1'b1;
    end else begin
      pending_nxt_s = pending_r;
    end
    case (state_r)
      IDLE: begin
        if (trig_s || pending_r) begin
          state_nxt_s    = START;
          cnt_nxt_s      = '0;
          bit_idx_nxt_s  = 3'd0;
          byte_idx_nxt_s = 3'd0;
          load_s         = 1'b1;
          pending_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          cnt_nxt_s     = '0;
          bit_idx_nxt_s = 3'd0;
          state_nxt_s   = DATA;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_nxt_s = '0;
          if (bit_idx_r == 3'd7) begin
            state_nxt_s = STOP;
          end else begin
            bit_idx_nxt_s = bit_idx_r + 3'd1;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end_s) begin
          cnt_nxt_s = '0;
          if (byte_idx_r != 3'd7) begin
            byte_idx_nxt_s = byte_idx_r + 3'd1;
            state_nxt_s    = START;
          end else begin
            done_s = 1'b1;
            // Back-to-back restart keeps busy high with a fresh snapshot
            if (pending_r || trig_s) begin
              state_nxt_s    = START;
              byte_idx_nxt_s = 3'd0;
              load_s         = 1'b1;
              pending_nxt_s  = 1'b0;
            end else begin
              state_nxt_s = IDLE;
            end
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM and bit/byte counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      bit_idx_r  <= 3'd0;
      byte_idx_r <= 3'd0;
      pending_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      bit_idx_r  <= bit_idx_nxt_s;
      byte_idx_r <= byte_idx_nxt_s;
      pending_r  <= pending_nxt_s;
    end
  end

  // Input snapshot taken at the accept edge
  always_ff @(posedge clk) begin
    if (rst) begin
      temp_r  <= 2'd0;
      hum_r   <= 2'd0;
      light_r <= 2'd0;
      soil_r  <= 2'd0;
      fault_r <= 8'd0;
      act_r   <= 8'd0;
      csum_r  <= 8'd0;
    end else if (load_s) begin
      temp_r  <= sensor_temp;
      hum_r   <= sensor_humidity;
      light_r <= sensor_light;
      soil_r  <= sensor_soil;
      fault_r <= fault_flags;
      act_r   <= actuator_status;
      csum_r  <= calc_csum(sensor_temp, sensor_humidity, sensor_light, sensor_soil,
                           fault_flags, actuator_status);
    end else begin
      csum_r <= csum_r;
    end
  end

  // Current byte and serial line level
  always_comb begin
    cur_byte_s = 8'hAA;
    tx_bit_s   = 1'b1;
    case (byte_idx_r)
      3'd0:    cur_byte_s = 8'hAA;
      3'd1:    cur_byte_s = {6'd0, temp_r};
      3'd2:    cur_byte_s = {6'd0, hum_r};
      3'd3:    cur_byte_s = {6'd0, light_r};
      3'd4:    cur_byte_s = {6'd0, soil_r};
      3'd5:    cur_byte_s = fault_r;
      3'd6:    cur_byte_s = act_r;
      3'd7:    cur_byte_s = csum_r;
      default: cur_byte_s = 8'hAA;
    endcase
    case (state_r)
      IDLE:    tx_bit_s = 1'b1;
      START:   tx_bit_s = 1'b0;
      DATA:    tx_bit_s = cur_byte_s[bit_idx_r];
      STOP:    tx_bit_s = 1'b1;
      default: tx_bit_s = 1'b1;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      uart_tx_r   <= 1'b1;
      busy_r      <= 1'b0;
      pkt_done_r  <= 1'b0;
      pkt_count_r <= 8'd0;
    end else begin
      uart_tx_r  <= tx_bit_s;
      busy_r     <= (state_r != IDLE);
      pkt_done_r <= done_s;
      if (done_s) begin
        pkt_count_r <= pkt_count_r + 8'd1;
      end else begin
        pkt_count_r <= pkt_count_r;
      end
    end
  end

  assign uart_tx   = uart_tx_r;
  assign busy      = busy_r;
  assign pkt_done  = pkt_done_r;
  assign pkt_count = pkt_count_r;

endmodule

// File: tb/tb_sensor_packet_tx.sv
// Scoreboard bench for sensor_packet_tx: expected bytes are queued by the stimulus,
// a UART decoder pops and compares each received byte.
module tb_sensor_packet_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_auto = 1'b1;
  logic [1:0] temp = 2'd0, hum = 2'd0, light = 2'd0, soil = 2'd0;
  logic [7:0] fault = 8'd0, act = 8'd0;
  logic       send_req = 1'b0;
  logic       uart_tx, busy, pkt_done;
  logic [7:0] pkt_count;
  logic       auto_tx, auto_busy, auto_done;
  logic [7:0] auto_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_ctr  = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int busy_drops = 0;
  logic busy_prev = 1'b0;
  logic [7:0] exp_q[$];

  logic       dec_active = 1'b0;
  int         dec_cyc = 0;
  logic [7:0] dec_byte = 8'd0;
  int         auto_n = 0;
  int         auto_last = 0;

  sensor_packet_tx #(.CLKS_PER_BIT(32'd4), .AUTO_PERIOD(32'd0)) u_dut (
    .clk(clk), .rst(rst), .sensor_temp(temp), .sensor_humidity(hum),
    .sensor_light(light), .sensor_soil(soil), .fault_flags(fault),
    .actuator_status(act), .send_req(send_req), .uart_tx(uart_tx),
    .busy(busy), .pkt_done(pkt_done), .pkt_count(pkt_count)
  );

  sensor_packet_tx #(.CLKS_PER_BIT(32'd1), .AUTO_PERIOD(32'd100)) u_auto (
    .clk(clk), .rst(rst_auto), .sensor_temp(temp), .sensor_humidity(hum),
    .sensor_light(light), .sensor_soil(soil), .fault_flags(fault),
    .actuator_status(act), .send_req(1'b0), .uart_tx(auto_tx),
    .busy(auto_busy), .pkt_done(auto_done), .pkt_count(auto_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_ctr++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // UART decoder and event monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (pkt_done) begin
      done_cnt++;
      last_done_cyc = cyc_ctr;
    end
    if (busy_prev && !busy) busy_drops++;
    busy_prev = busy;
    if (rst) begin
      dec_active = 1'b0;
    end else if (!dec_active) begin
      if (uart_tx == 1'b0) begin
        dec_active = 1'b1;
        dec_cyc = 0;
      end
    end else begin
      dec_cyc++;
      if (dec_cyc >= CPB + CPB/2 && dec_cyc < 9*CPB && ((dec_cyc - CPB/2) % CPB) == 0)
        dec_byte[(dec_cyc - CPB/2)/CPB - 1] = uart_tx;
      if (dec_cyc == 9*CPB + CPB/2) begin
        check("stop_bit", 32'(uart_tx), 32'd1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got %0h expected none", dec_byte);
        end else begin
          check("pkt_byte", 32'(dec_byte), 32'(exp_q.pop_front()));
        end
        dec_active = 1'b0;
      end
    end
    if (auto_done) begin
      if (auto_n > 0) check("auto_period", 32'(cyc_ctr - auto_last), 32'd100);
      auto_last = cyc_ctr;
      auto_n++;
      if (auto_n == 255) check("auto_count_255", 32'(auto_count), 32'd255);
      if (auto_n == 256) check("auto_count_wrap", 32'(auto_count), 32'd0);
    end
  end

  task automatic push_pkt(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                          input logic [7:0] b4, input logic [7:0] b5, input logic [7:0] b6,
                          input logic [7:0] b7);
    exp_q.push_back(8'hAA);
    exp_q.push_back(b1); exp_q.push_back(b2); exp_q.push_back(b3); exp_q.push_back(b4);
    exp_q.push_back(b5); exp_q.push_back(b6); exp_q.push_back(b7);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic send_pulse();
    @(posedge clk); #1 send_req = 1'b1;
    @(posedge clk); #1 send_req = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit);
    int c = 0;
    while (done_cnt < target && c < limit) begin
      @(negedge clk);
      c++;
    end
    check("pkt_done_timeout", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic set_inputs(input logic [1:0] t, input logic [1:0] h, input logic [1:0] l,
                            input logic [1:0] s, input logic [7:0] f, input logic [7:0] a);
    temp = t; hum = h; light = l; soil = s; fault = f; act = a;
  endtask

  initial begin
    int accept_cyc;
    int base;
    int drops0;
    do_reset();
    @(negedge clk);
    check("rst_tx", 32'(uart_tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(pkt_done), 32'd0);
    check("rst_count", 32'(pkt_count), 32'd0);

    // T1: basic packet and latency
    set_inputs(2'd2, 2'd2, 2'd2, 2'd2, 8'h00, 8'h05);
    push_pkt(8'h02, 8'h02, 8'h02, 8'h02, 8'h00, 8'h05, 8'h0D);
    base = done_cnt;
    send_pulse();
    accept_cyc = cyc_ctr;
    @(negedge clk);
    check("t1_tx_at_accept", 32'(uart_tx), 32'd1);
    check("t1_busy_at_accept", 32'(busy), 32'd0);
    @(negedge clk);
    check("t1_start_bit", 32'(uart_tx), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    wait_done(base + 1, 600);
    check("t1_done_cycle", 32'(last_done_cyc - accept_cyc), 32'd320);
    @(negedge clk);
    check("t1_busy_drop", 32'(busy), 32'd0);
    check("t1_count", 32'(pkt_count), 32'd1);

    // T2: checksum wraps mod 256
    do_reset();
    set_inputs(2'd3, 2'd3, 2'd3, 2'd3, 8'hFF, 8'hFF);
    push_pkt(8'h03, 8'h03, 8'h03, 8'h03, 8'hFF, 8'hFF, 8'h0A);
    base = done_cnt;
    send_pulse();
    wait_done(base + 1, 600);
    repeat (3) @(negedge clk);
    check("t2_count", 32'(pkt_count), 32'd1);

    // T3: two requests while busy give exactly one back-to-back packet
    do_reset();
    set_inputs(2'd1, 2'd0, 2'd3, 2'd2, 8'h12, 8'h80);
    push_pkt(8'h01, 8'h00, 8'h03, 8'h02, 8'h12, 8'h80, 8'h98);
    push_pkt(8'h01, 8'h00, 8'h03, 8'h02, 8'h12, 8'h80, 8'h98);
    base = done_cnt;
    send_pulse();
    drops0 = busy_drops;
    repeat (130) @(posedge clk);
    send_pulse();
    repeat (80) @(posedge clk);
    send_pulse();
    wait_done(base + 1, 400);
    @(negedge clk);
    check("t3_restart_start_bit", 32'(uart_tx), 32'd0);
    check("t3_restart_busy", 32'(busy), 32'd1);
    wait_done(base + 2, 400);
    repeat (100) @(negedge clk);
    check("t3_busy_drops", 32'(busy_drops - drops0), 32'd1);
    check("t3_pkt_total", 32'(done_cnt - base), 32'd2);
    check("t3_count", 32'(pkt_count), 32'd2);

    // T4: mid-packet input change only affects the next packet
    do_reset();
    set_inputs(2'd2, 2'd2, 2'd2, 2'd2, 8'h00, 8'h05);
    push_pkt(8'h02, 8'h02, 8'h02, 8'h02, 8'h00, 8'h05, 8'h0D);
    base = done_cnt;
    send_pulse();
    repeat (100) @(posedge clk);
    #1 act = 8'h33;
    wait_done(base + 1, 400);
    push_pkt(8'h02, 8'h02, 8'h02, 8'h02, 8'h00, 8'h33, 8'h3B);
    send_pulse();
    wait_done(base + 2, 600);
    repeat (3) @(negedge clk);
    check("t4_count", 32'(pkt_count), 32'd2);

    // T5: reset during byte 4 aborts, then a clean packet follows
    set_inputs(2'd0, 2'd1, 2'd2, 2'd3, 8'hA5, 8'h5A);
    exp_q.push_back(8'hAA); exp_q.push_back(8'h00);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    send_pulse();
    repeat (175) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t5_tx_after_rst", 32'(uart_tx), 32'd1);
    check("t5_busy_after_rst", 32'(busy), 32'd0);
    check("t5_count_after_rst", 32'(pkt_count), 32'd0);
    check("t5_bytes_before_rst", 32'(exp_q.size()), 32'd0);
    repeat (5) @(negedge clk);
    check("t5_line_idle", 32'(uart_tx), 32'd1);
    push_pkt(8'h00, 8'h01, 8'h02, 8'h03, 8'hA5, 8'h5A, 8'h05);
    base = done_cnt;
    send_pulse();
    wait_done(base + 1, 600);
    repeat (3) @(negedge clk);
    check("t5_count", 32'(pkt_count), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    // T6: automatic period, counter wrap after 256 packets
    @(posedge clk); #1 rst_auto = 1'b0;
    begin
      int c = 0;
      while (auto_n < 256 && c < 30000) begin
        @(negedge clk);
        c++;
      end
    end
    check("t6_auto_pkts", 32'(auto_n), 32'd256);
    check("t6_auto_count", 32'(auto_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
